multi_channel_pwm_gen: RTL and testbench

//   CH-channel programmable square/PWM generator. Successor to the fixed 4-output divider.

---
 rtl/multi_channel_pwm_gen.sv | 131 +++++++++++++
 tb/tb_multi_channel_pwm_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_pwm_gen.sv
// Multi-channel programmable PWM / square-wave generator.
// Each channel owns a free-running counter with a runtime period (terminal count) and a
// high threshold. New settings land in a shadow register and are applied glitch-free on the
// channel's wrap (or immediately on sync), so a running waveform never sees a torn period.
// Optional feature macro: PWM_READBACK_EN adds a registered counter readback port pair.
module multi_channel_pwm_gen #(
  parameter int unsigned CH         = 4,
  parameter int unsigned N          = 30,
  parameter int unsigned DEF_PERIOD = 500000000,
  parameter int unsigned DEF_RATIO  = 10,
  localparam int unsigned CW        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic          clk,
  input  logic          rs,
  input  logic          en,
  input  logic          sync,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [N-1:0]  cfg_period,
  input  logic [N-1:0]  cfg_thresh,
`ifdef PWM_READBACK_EN
  input  logic [CW-1:0] rd_ch,
  output logic [N-1:0]  rd_cnt,
`endif
  output logic [CH-1:0] q,
  output logic [CH-1:0] tick,
  output logic [CH-1:0] cfg_pend
);

  // Reset period of channel k: DEF_PERIOD divided k times by DEF_RATIO.
  function automatic logic [N-1:0] def_per(input int unsigned k);
    int unsigned v;
    v = DEF_PERIOD;
    for (int unsigned i = 0; i < k; i++) begin
      v = v / DEF_RATIO;
    end
    return v[N-1:0];
  endfunction

`ifdef PWM_READBACK_EN
  logic [N-1:0] cnt_all [CH];
`endif

  for (genvar k = 0; k < CH; k++) begin : g_ch
    localparam logic [N-1:0] DefPer = def_per(k);
    localparam logic [N-1:0] DefThr = DefPer >> 1;

    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] per_q, per_d;
    logic [N-1:0] thr_q, thr_d;
    logic [N-1:0] sper_q, sper_d;
    logic [N-1:0] sthr_q, sthr_d;
    logic         pend_q, pend_d;
    logic         wrap;
    logic         wr_hit;
    logic         apply;

    assign wrap   = (cnt_q == per_q);
    assign wr_hit = cfg_we && (cfg_ch == CW'(k));
    // Apply uses pre-edge pend/shadow, so a write on the wrap cycle waits for the next wrap.
    assign apply  = pend_q && (sync || (en && wrap));

    // Next-state: counter advance, shadow apply, then shadow load (load wins over clear).
    always_comb begin
      cnt_d  = cnt_q;
      per_d  = per_q;
      thr_d  = thr_q;
      sper_d = sper_q;
      sthr_d = sthr_q;
      pend_d = pend_q;
      if (sync) begin
        cnt_d = '0;
      end else if (en) begin
        // cnt > per is only reachable after a shrinking apply; fold it back to 0.
        cnt_d = (wrap || (cnt_q > per_q)) ? '0 : cnt_q + 1'b1;
      end
      if (apply) begin
        per_d  = sper_q;
        thr_d  = sthr_q;
        pend_d = 1'b0;
      end
      if (wr_hit) begin
        sper_d = cfg_period;
        sthr_d = cfg_thresh;
        pend_d = 1'b1;
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rs) begin
      if (rs) begin
        cnt_q  <= '0;
        per_q  <= DefPer;
        thr_q  <= DefThr;
        sper_q <= DefPer;
        sthr_q <= DefThr;
        pend_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        per_q  <= per_d;
        thr_q  <= thr_d;
        sper_q <= sper_d;
        sthr_q <= sthr_d;
        pend_q <= pend_d;
      end
    end

    assign q[k]        = (cnt_q >= thr_q);
    assign tick[k]     = en && !sync && wrap;
    assign cfg_pend[k] = pend_q;

`ifdef PWM_READBACK_EN
    assign cnt_all[k] = cnt_q;
`endif
  end

`ifdef PWM_READBACK_EN
  logic rd_ok;
  assign rd_ok = (32'(rd_ch) < CH);

  // Registered counter readback; out-of-range channel reads as 0.
  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      rd_cnt <= '0;
    end else begin
      rd_cnt <= rd_ok ? cnt_all[rd_ch] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_multi_channel_pwm_gen.sv
// Directed bench for multi_channel_pwm_gen with CH=2, N=8, DEF_PERIOD=9, DEF_RATIO=3.
// Time index e counts rising edges since the first enable; outputs are sampled on falling edges.
module tb_multi_channel_pwm_gen;
  localparam int unsigned CH = 2;
  localparam int unsigned N  = 8;
  localparam int unsigned CW = 1;

  logic          clk = 1'b0;
  logic          rs;
  logic          en;
  logic          sync;
  logic          cfg_we;
  logic [CW-1:0] cfg_ch;
  logic [N-1:0]  cfg_period;
  logic [N-1:0]  cfg_thresh;
  logic [CH-1:0] q;
  logic [CH-1:0] tick;
  logic [CH-1:0] cfg_pend;
`ifdef PWM_READBACK_EN
  logic [CW-1:0] rd_ch;
  logic [N-1:0]  rd_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_channel_pwm_gen #(
    .CH(CH),
    .N(N),
    .DEF_PERIOD(9),
    .DEF_RATIO(3)
  ) dut (
    .clk(clk),
    .rs(rs),
    .en(en),
    .sync(sync),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_period(cfg_period),
    .cfg_thresh(cfg_thresh),
`ifdef PWM_READBACK_EN
    .rd_ch(rd_ch),
    .rd_cnt(rd_cnt),
`endif
    .q(q),
    .tick(tick),
    .cfg_pend(cfg_pend)
  );

  task automatic chk2(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic ch, input logic [N-1:0] p, input logic [N-1:0] t);
    cfg_we     = 1'b1;
    cfg_ch     = ch;
    cfg_period = p;
    cfg_thresh = t;
  endtask

  initial begin
    logic q0e, q1e, t0e, t1e, p0e, p1e;
    int c;
    rs = 1'b1; en = 1'b0; sync = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_thresh = '0;
`ifdef PWM_READBACK_EN
    rd_ch = 1'b1;
`endif
    #1;
    chk2("rst_q", q, 2'b00);
    chk2("rst_tick", tick, 2'b00);
    chk2("rst_pend", cfg_pend, 2'b00);
`ifdef PWM_READBACK_EN
    chkn("rst_rd", rd_cnt, 8'd0);
`endif

    // Release reset and run with defaults: ch0 P=9,T=4; ch1 P=3,T=1.
    @(negedge clk);
    rs = 1'b0;
    en = 1'b1;
    #1;
    @(negedge clk);
    // One edge has passed with en high: restart time base with a clean reference.
    // Realign: wait until both counters are back to 0 at e=40 by counting from e=1.
    for (int e = 1; e < 40; e++) begin
      chk2("def_q", q, {(e % 4) >= 1, (e % 10) >= 4});
      chk2("def_tick", tick, {(e % 4) == 3, (e % 10) == 9});
      chk2("def_pend", cfg_pend, 2'b00);
      @(negedge clk);
    end

    // Config sequence: ch0 retarget, ch1 write on wrap, ch1 double write.
    for (int e = 40; e < 100; e++) begin
      if (e < 50) begin
        q0e = (e - 40) >= 4;
        t0e = (e == 49);
      end else begin
        q0e = 1'b1;
        t0e = ((e - 50) % 6) == 5;
      end
      if (e < 68) begin
        q1e = (e % 4) >= 1;
        t1e = (e % 4) == 3;
      end else if (e < 86) begin
        c   = (e - 68) % 6;
        q1e = c >= 2;
        t1e = c == 5;
      end else begin
        q1e = 1'b0;
        t1e = ((e - 86) % 3) == 2;
      end
      p0e = (e >= 41) && (e <= 49);
      p1e = ((e >= 64) && (e <= 67)) || ((e >= 81) && (e <= 85));
      chk2("cfg_q", q, {q1e, q0e});
      chk2("cfg_tick", tick, {t1e, t0e});
      chk2("cfg_pend", cfg_pend, {p1e, p0e});
      case (e)
        40: wr(1'b0, 8'd5, 8'd0);
        63: wr(1'b1, 8'd5, 8'd2);
        80: wr(1'b1, 8'd7, 8'd0);
        81: wr(1'b1, 8'd2, 8'd3);
        41, 64, 82: cfg_we = 1'b0;
        default: ;
      endcase
      @(negedge clk);
    end

    // e=100: cnt0=2, cnt1=2. Freeze for 7 cycles with a ch0 write accepted meanwhile.
    en = 1'b0;
    wr(1'b0, 8'd3, 8'd2);
    #1;
    chk2("hold_tick0", tick, 2'b00);
    for (int h = 1; h <= 7; h++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      chk2("hold_q", q, 2'b01);
      chk2("hold_tick", tick, 2'b00);
      chk2("hold_pend", cfg_pend, 2'b01);
    end
    // Held cnt1=2 is ch1's terminal count, so tick1 fires as soon as counting resumes.
    en = 1'b1;
    #1;
    chk2("resume_tick", tick, 2'b10);
    @(negedge clk);
    chk2("resume_tick2", tick, 2'b00);
    chk2("resume_pend", cfg_pend, 2'b01);
    @(negedge clk);
    sync = 1'b1;
    #1;
    chk2("sync_tick", tick, 2'b00);
    @(negedge clk);
    sync = 1'b0;
    // After sync: ch0 P=3,T=2 applied; ch1 P=2,T=3.
    for (int s = 0; s < 14; s++) begin
      chk2("sync_q", q, {1'b0, (s % 4) >= 2});
      chk2("sync_tick", tick, {(s % 3) == 2, (s % 4) == 3});
      chk2("sync_pend", cfg_pend, 2'b00);
      @(negedge clk);
    end

    // s=14: cnt0=2. Leave a ch0 write pending, then reset asynchronously.
    wr(1'b0, 8'd1, 8'd1);
    @(negedge clk);
    cfg_we = 1'b0;
    chk2("pre_rst_pend", cfg_pend, 2'b01);
    chk2("pre_rst_q", q, 2'b01);
    #2;
    rs = 1'b1;
    #1;
    chk2("arst_q", q, 2'b00);
    chk2("arst_tick", tick, 2'b00);
    chk2("arst_pend", cfg_pend, 2'b00);
`ifdef PWM_READBACK_EN
    chkn("arst_rd", rd_cnt, 8'd0);
`endif
    @(negedge clk);
    rs = 1'b0;
    #1;
    // Defaults again; the discarded ch0 write would show as a 2-cycle tick0.
    for (int i = 0; i < 12; i++) begin
      chk2("post_q", q, {(i % 4) >= 1, (i % 10) >= 4});
      chk2("post_tick", tick, {(i % 4) == 3, (i % 10) == 9});
      chk2("post_pend", cfg_pend, 2'b00);
`ifdef PWM_READBACK_EN
      if (i == 0) chkn("rd_cnt", rd_cnt, 8'd0);
      else if (i <= 6) chkn("rd_cnt1", rd_cnt, 8'((i - 1) % 4));
      else chkn("rd_cnt0", rd_cnt, 8'((i - 1) % 10));
      if (i == 6) rd_ch = 1'b0;
`endif
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
